// File: rtl/bid_txn_sched.sv
// Four-master bidding scheduler: credit-funded bids arbitrate for one shared slave path,
// the grant is held for a whole transaction, and balances are charged at release and refilled periodically.
module bid_txn_sched #(
    parameter int BID_W       = 4,
    parameter int BAL_W       = 16,
    parameter int INIT_BAL    = 900,
    parameter int MAX_TXN_CYC = 16,
    parameter int AGE_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           req_valid,
    input  logic [4*BID_W-1:0]   req_bid,
    input  logic                 txn_done,
    input  logic [BAL_W-1:0]     refill_amt,
    input  logic [15:0]          refill_period,
    input  logic [BAL_W-1:0]     max_balance,
    output logic [3:0]           grant,
    output logic [1:0]           grant_idx,
    output logic                 busy,
    output logic                 timeout,
    output logic [4*BAL_W-1:0]   balance
);

    localparam int TMR_W = $clog2(MAX_TXN_CYC) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MAX_TXN_CYC - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state;
    logic [BAL_W-1:0] bal_q [4];
    logic [AGE_W-1:0] age_q [4];
    logic [TMR_W-1:0] timer;
    logic [15:0]      refill_cnt;
    logic [BAL_W-1:0] win_eff;
    logic [3:0]       arb_req;

    logic [BAL_W-1:0] eff      [4];
    logic [BAL_W:0]   charged  [4];
    logic [BAL_W:0]   refilled [4];
    logic [BAL_W-1:0] bal_next [4];
    logic [1:0]       sel_idx;
    logic [BAL_W-1:0] sel_eff;
    logic [AGE_W-1:0] sel_age;
    logic             sel_found;
    logic             release_now;
    logic             refill_evt;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sel_idx   = '0;
        sel_eff   = '0;
        sel_age   = '0;
        sel_found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            eff[i] = (BAL_W'(req_bid[i*BID_W +: BID_W]) < bal_q[i])
                   ? BAL_W'(req_bid[i*BID_W +: BID_W]) : bal_q[i];
            // Strict comparisons while scanning upward keep the lowest index on a full tie.
            if (req_valid[i] && (!sel_found || eff[i] > sel_eff ||
                                 (eff[i] == sel_eff && age_q[i] > sel_age))) begin
                sel_found = 1'b1;
                sel_idx   = 2'(i);
                sel_eff   = eff[i];
                sel_age   = age_q[i];
            end
        end
    end

    assign release_now = (state == GRANT) &&
                         (txn_done || !req_valid[grant_idx] || timer == TMR_LAST);
    assign refill_evt  = (refill_period != 16'd0) && (refill_cnt == refill_period - 16'd1);

    // Charge first (floored at zero), then refill with ceiling; one extra bit keeps the sum from wrapping.
    always_comb begin
        balance = '0;
        for (int i = 0; i < 4; i++) begin
            charged[i] = {1'b0, bal_q[i]};
            if (release_now && grant_idx == 2'(i))
                charged[i] = (bal_q[i] >= win_eff) ? {1'b0, bal_q[i] - win_eff} : '0;
            refilled[i] = charged[i] + {1'b0, refill_amt};
            if (refill_evt)
                bal_next[i] = (refilled[i] > {1'b0, max_balance}) ? max_balance
                                                                 : refilled[i][BAL_W-1:0];
            else
                bal_next[i] = charged[i][BAL_W-1:0];
            balance[i*BAL_W +: BAL_W] = bal_q[i];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            grant      <= '0;
            grant_idx  <= '0;
            busy       <= 1'b0;
            timeout    <= 1'b0;
            timer      <= '0;
            refill_cnt <= '0;
            win_eff    <= '0;
            arb_req    <= '0;
            // NOTE: the balance/age arrays are a handful of flops, not RAM, so they take a real reset.
            for (int i = 0; i < 4; i++) begin
                bal_q[i] <= BAL_W'(INIT_BAL);
                age_q[i] <= '0;
            end
        end else begin
            if (refill_period == 16'd0 || refill_evt)
                refill_cnt <= '0;
            else
                refill_cnt <= refill_cnt + 16'd1;

            for (int i = 0; i < 4; i++)
                bal_q[i] <= bal_next[i];

            case (state)
                IDLE: begin
                    timeout <= 1'b0;
                    if (|req_valid) begin
                        state     <= GRANT;
                        grant     <= 4'b0001 << sel_idx;
                        grant_idx <= sel_idx;
                        busy      <= 1'b1;
                        win_eff   <= sel_eff;
                        arb_req   <= req_valid;
                        timer     <= '0;
                        timeout   <= (MAX_TXN_CYC == 1);
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state   <= IDLE;
                        grant   <= '0;
                        busy    <= 1'b0;
                        timeout <= 1'b0;
                        timer   <= '0;
                        for (int i = 0; i < 4; i++) begin
                            if (grant_idx == 2'(i))
                                age_q[i] <= '0;
                            else if (arb_req[i] && age_q[i] != '1)
                                age_q[i] <= age_q[i] + 1'b1;
                        end
                    end else begin
                        timer   <= timer + 1'b1;
                        // Pulse lands in the last permitted grant cycle, the one that forces release.
                        timeout <= (timer + 1'b1 == TMR_LAST);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bid_txn_sched.sv
// Directed bench for bid_txn_sched: expected winners are queued when requests are driven
// and popped when the grant appears; balances and pulses are checked against hand-derived values.
module tb_bid_txn_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_bid;
    logic        txn_done;
    logic [15:0] refill_amt;
    logic [15:0] refill_period;
    logic [15:0] max_balance;
    logic [3:0]  grant;
    logic [1:0]  grant_idx;
    logic        busy;
    logic        timeout;
    logic [63:0] balance;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    bid_txn_sched dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_bid       (req_bid),
        .txn_done      (txn_done),
        .refill_amt    (refill_amt),
        .refill_period (refill_period),
        .max_balance   (max_balance),
        .grant         (grant),
        .grant_idx     (grant_idx),
        .busy          (busy),
        .timeout       (timeout),
        .balance       (balance)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic [63:0] bals(input int b0, input int b1, input int b2, input int b3);
        return {16'(b3), 16'(b2), 16'(b1), 16'(b0)};
    endfunction

    // Requests are already driven; the grant must show on the very next edge.
    task automatic expect_grant(input string tag);
        int n;
        int exp_idx;
        tick();
        n = 1;
        while (!busy && n < 4) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            exp_idx = exp_q.pop_front();
            check({tag, "_grant"}, 64'(grant), 64'(4'b0001 << exp_idx));
            check({tag, "_idx"}, 64'(grant_idx), 64'(exp_idx));
        end
    endtask

    initial begin
        rst           = 1'b0;
        req_valid     = 4'b0000;
        req_bid       = '0;
        txn_done      = 1'b0;
        refill_amt    = 16'd0;
        refill_period = 16'd0;
        max_balance   = 16'd1000;

        // Reset state
        tick();
        tick();
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_timeout", 64'(timeout), 64'd0);
        check("rst_bal", balance, bals(900, 900, 900, 900));
        rst = 1'b1;
        tick();

        // Basic bid: master 2 (9) beats master 0 (5)
        req_valid = 4'b0101;
        req_bid   = {4'd0, 4'd9, 4'd0, 4'd5};
        exp_q.push_back(2);
        expect_grant("basic");
        tick();
        tick();
        txn_done  = 1'b1;
        req_valid = 4'b0001;
        tick();
        txn_done  = 1'b0;
        check("basic_idle_gap", 64'(grant), 64'd0);
        check("basic_charge", balance, bals(900, 900, 891, 900));
        exp_q.push_back(0);
        expect_grant("aged_m0");
        txn_done = 1'b1;
        tick();
        txn_done = 1'b0;
        check("m0_charge", balance, bals(895, 900, 891, 900));

        // Ties: all bid 7, ages equal -> master 0, then master 1 by age and index
        req_valid = 4'b1111;
        req_bid   = {4'd7, 4'd7, 4'd7, 4'd7};
        exp_q.push_back(0);
        expect_grant("tie_first");
        txn_done = 1'b1;
        tick();
        txn_done = 1'b0;
        check("tie_charge0", balance, bals(888, 900, 891, 900));
        exp_q.push_back(1);
        expect_grant("tie_second");
        txn_done  = 1'b1;
        req_valid = 4'b0000;
        tick();
        txn_done  = 1'b0;
        check("tie_charge1", balance, bals(888, 893, 891, 900));

        // Refill clamp-down: ceiling below balances pulls all of them to 10
        refill_period = 16'd1;
        refill_amt    = 16'd0;
        max_balance   = 16'd10;
        tick();
        refill_period = 16'd0;
        check("clamp_down", balance, bals(10, 10, 10, 10));

        // Affordability: bring master 1 to 3, then 15 (eff 3) loses to 4 (eff 4)
        req_valid = 4'b0010;
        req_bid   = {4'd0, 4'd0, 4'd7, 4'd0};
        exp_q.push_back(1);
        expect_grant("drain_m1");
        txn_done  = 1'b1;
        req_valid = 4'b0000;
        tick();
        txn_done  = 1'b0;
        check("drain_bal", balance, bals(10, 3, 10, 10));
        req_valid = 4'b1010;
        req_bid   = {4'd4, 4'd0, 4'd15, 4'd0};
        exp_q.push_back(3);
        expect_grant("afford");
        txn_done  = 1'b1;
        req_valid = 4'b0000;
        tick();
        txn_done  = 1'b0;
        check("afford_charge", balance, bals(10, 3, 10, 6));

        // Timeout: master 2 never completes
        req_valid = 4'b0100;
        req_bid   = {4'd0, 4'd9, 4'd0, 4'd0};
        exp_q.push_back(2);
        expect_grant("to");
        repeat (14) tick();
        check("to_cyc15_pulse", 64'(timeout), 64'd0);
        check("to_cyc15_busy", 64'(busy), 64'd1);
        tick();
        check("to_cyc16_pulse", 64'(timeout), 64'd1);
        check("to_cyc16_grant", 64'(grant), 64'b0100);
        req_valid = 4'b0000;
        tick();
        check("to_release_grant", 64'(grant), 64'd0);
        check("to_release_pulse", 64'(timeout), 64'd0);
        check("to_charge", balance, bals(10, 3, 1, 6));

        // txn_done coincident with timeout: one pulse, one release, one charge
        req_valid = 4'b0001;
        req_bid   = {4'd0, 4'd0, 4'd0, 4'd2};
        exp_q.push_back(0);
        expect_grant("to_done");
        repeat (15) tick();
        check("to_done_pulse", 64'(timeout), 64'd1);
        txn_done  = 1'b1;
        req_valid = 4'b0000;
        tick();
        txn_done  = 1'b0;
        check("to_done_busy", 64'(busy), 64'd0);
        check("to_done_charge", balance, bals(8, 3, 1, 6));
        tick();
        check("to_done_single", 64'({busy, timeout}), 64'd0);

        // Refill: period 10, +50, ceiling 920, with a coincident charge of 9 on master 0
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        refill_period = 16'd10;
        refill_amt    = 16'd50;
        max_balance   = 16'd920;
        req_valid     = 4'b0001;
        req_bid       = {4'd0, 4'd0, 4'd0, 4'd9};
        exp_q.push_back(0);
        expect_grant("refill_m0");
        repeat (8) tick();
        check("refill_before", balance, bals(900, 900, 900, 900));
        txn_done  = 1'b1;
        req_valid = 4'b0000;
        tick();
        txn_done  = 1'b0;
        check("refill_edge", balance, bals(920, 920, 920, 920));
        refill_period = 16'd0;
        repeat (100) tick();
        check("refill_off", balance, bals(920, 920, 920, 920));

        // Asynchronous reset in the middle of a grant
        req_valid = 4'b0100;
        req_bid   = {4'd0, 4'd9, 4'd0, 4'd0};
        exp_q.push_back(2);
        expect_grant("mid_rst");
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_grant", 64'(grant), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_bal", balance, bals(900, 900, 900, 900));
        req_valid = 4'b0000;
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_idle", 64'(busy), 64'd0);
        req_valid = 4'b0100;
        exp_q.push_back(2);
        expect_grant("post_rst");
        txn_done  = 1'b1;
        req_valid = 4'b0000;
        tick();
        txn_done  = 1'b0;
        check("post_rst_charge", balance, bals(900, 900, 891, 900));

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
